// File: rtl/pp_place_accum_if.sv
// ---------------------------------------------------------------------------
// pp_place_accum_if
// Purpose : bundles the partial-product handshake and result signals of
//           pp_place_accum.
// Handshake: a partial is transferred on a rising clk edge where
//           pp_valid && pp_ready are both high. pp_in and pp_sel must be
//           stable while pp_valid is high. The source may deassert
//           pp_valid at any time. pp_ready does not depend on pp_valid.
// Signals : start    - begin a new product (master -> slave)
//           pp_valid - pp_in/pp_sel valid (master -> slave)
//           pp_in    - partial product, 2*NIB_W bits (master -> slave)
//           pp_sel   - position code of the partial (master -> slave)
//           pp_ready - accumulator accepts a partial (slave -> master)
//           busy     - run in progress (slave -> master)
//           product  - final product, 4*NIB_W bits (slave -> master)
//           done     - one-cycle product-updated pulse (slave -> master)
//           err_dup  - one-cycle duplicate-position pulse (slave -> master)
// ---------------------------------------------------------------------------
interface pp_place_accum_if #(
  parameter int NIB_W = 4
);
  logic                 start;
  logic                 pp_valid;
  logic [2*NIB_W-1:0]   pp_in;
  logic [1:0]           pp_sel;
  logic                 pp_ready;
  logic                 busy;
  logic [4*NIB_W-1:0]   product;
  logic                 done;
  logic                 err_dup;

  modport master (
    output start, pp_valid, pp_in, pp_sel,
    input  pp_ready, busy, product, done, err_dup
  );

  modport slave (
    input  start, pp_valid, pp_in, pp_sel,
    output pp_ready, busy, product, done, err_dup
  );
endinterface

// File: rtl/pp_place_accum.sv
// ---------------------------------------------------------------------------
// pp_place_accum
// Purpose : places each nibble x nibble partial product at its bit weight and
//           accumulates the four partials of an 8x8 multiply into the full
//           product. Partials may arrive in any order, with gaps.
// Ports   : clk     - system clock, rising edge
//           reset   - synchronous, active-high
//           bus     - pp_place_accum_if slave modport (handshake + results)
//           o_state - debug view of the FSM state (0 IDLE, 1 ACCUM, 2 DONE)
// ---------------------------------------------------------------------------
module pp_place_accum #(
  parameter int NIB_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pp_place_accum_if.slave       bus,
  output logic [1:0]            o_state
);
  localparam int ACC_W = 4 * NIB_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [3:0]         r_seen;
  logic [ACC_W-1:0]   r_product;
  logic               r_err_dup;

  logic               w_accept;
  logic               w_dup;
  logic [ACC_W-1:0]   w_placed;
  logic [ACC_W-1:0]   w_acc_sum;
  logic [3:0]         w_seen_next;
  logic               w_complete;

  assign w_accept = (r_state == S_ACCUM) && bus.pp_valid;
  assign w_dup    = r_seen[bus.pp_sel];

  // Both cross terms (a_hi*b_lo, a_lo*b_hi) share the single-nibble weight.
  always_comb begin
    w_placed = '0;
    case (bus.pp_sel)
      2'b00:   w_placed = {{(2*NIB_W){1'b0}}, bus.pp_in};
      2'b01,
      2'b10:   w_placed = {{NIB_W{1'b0}}, bus.pp_in, {NIB_W{1'b0}}};
      default: w_placed = {bus.pp_in, {(2*NIB_W){1'b0}}};
    endcase
  end

  assign w_acc_sum   = r_acc + w_placed;
  assign w_seen_next = r_seen | (4'b0001 << bus.pp_sel);
  // A duplicate never completes a run: only a new position can fill seen.
  assign w_complete  = w_accept && !w_dup && (w_seen_next == 4'b1111);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ACCUM;
      S_ACCUM: if (w_complete) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_seen    <= 4'b0000;
      r_product <= '0;
      r_err_dup <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_err_dup <= w_accept && w_dup;
      if (r_state == S_IDLE && bus.start) begin
        r_acc  <= '0;
        r_seen <= 4'b0000;
      end else if (w_accept && !w_dup) begin
        r_acc  <= w_acc_sum;
        r_seen <= w_seen_next;
        // Loading product on the completing edge makes it visible during
        // DONE, aligned with the done pulse.
        if (w_complete) r_product <= w_acc_sum;
      end
    end
  end

  assign bus.pp_ready = (r_state == S_ACCUM);
  assign bus.busy     = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.product  = r_product;
  assign bus.err_dup  = r_err_dup;
  assign o_state      = r_state;
endmodule
